// File: rtl/tiro_inimigo.sv
// ============================================================================
// Module   : tiro_inimigo
// Purpose  : Enemy projectile generator: random cooldown, falling shot and ship-hit pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tiro_inimigo #(
  parameter int         TICK_DIV     = 320000,
  parameter int         VEL          = 4,
  parameter int         COOLDOWN_MIN = 50,
  parameter logic [7:0] LFSR_SEED    = 8'hA5,
  parameter int         NAVE_L       = 33,
  parameter int         NAVE_A       = 24,
  parameter int         TELA_A       = 480
) (
  input  logic       CLOCK_50,
  input  logic       resetInimigo,
  input  logic       pausa,
  input  logic       inimigo_vivo,
  input  logic [9:0] inimigo_x,
  input  logic [9:0] inimigo_y,
  input  logic [9:0] nave_x,
  input  logic [9:0] nave_y,
  output logic [9:0] bola_x,
  output logic [9:0] bola_y,
  output logic       ativa,
  output logic       acertou_nave
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CD_W  = $clog2(COOLDOWN_MIN + 32);
  localparam logic [DIV_W-1:0] c_div_max = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ESPERA = 2'd1,
    VOANDO = 2'd2
  } estado_t;

  estado_t          r_estado, w_estado_nxt;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_lfsr;
  logic [CD_W-1:0]  r_cd, w_cd_nxt;
  logic [9:0]       r_bola_x, w_bola_x_nxt;
  logic [9:0]       r_bola_y, w_bola_y_nxt;
  logic             r_ativa, w_ativa_nxt;
  logic             r_acertou, w_acertou_nxt;

  logic             w_tick;
  logic             w_fb;
  logic [CD_W-1:0]  w_cd_load;
  logic [10:0]      w_x_lanc;
  logic [9:0]       w_y_lanc;
  logic [10:0]      w_y_mov;
  logic             w_acerto;
  logic             w_fora;

  assign w_tick    = !pausa && (r_div == c_div_max);
  assign w_fb      = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_cd_load = CD_W'(COOLDOWN_MIN) + CD_W'(r_lfsr[4:0]);
  assign w_x_lanc  = {1'b0, inimigo_x} + 11'd16;
  assign w_y_lanc  = inimigo_y + 10'd24;
  assign w_y_mov   = {1'b0, r_bola_y} + 11'(VEL);

  // Hit box test uses the post-move y; bola_x never changes in flight.
  assign w_acerto = ({1'b0, nave_x} < {1'b0, r_bola_x}) &&
                    ({1'b0, r_bola_x} < ({1'b0, nave_x} + 11'(NAVE_L))) &&
                    ({1'b0, nave_y} < w_y_mov) &&
                    (w_y_mov < ({1'b0, nave_y} + 11'(NAVE_A)));
  assign w_fora   = (w_y_mov >= 11'(TELA_A));

  always_comb begin
    w_estado_nxt  = r_estado;
    w_cd_nxt      = r_cd;
    w_bola_x_nxt  = r_bola_x;
    w_bola_y_nxt  = r_bola_y;
    w_ativa_nxt   = r_ativa;
    w_acertou_nxt = 1'b0;
    case (r_estado)
      OCIOSO: begin
        w_ativa_nxt = 1'b0;
        if (inimigo_vivo) begin
          w_estado_nxt = ESPERA;
          w_cd_nxt     = w_cd_load;
        end
      end
      ESPERA: begin
        w_ativa_nxt = 1'b0;
        if (!inimigo_vivo) begin
          w_estado_nxt = OCIOSO;
        end else if ((r_cd == '0) && !pausa) begin
          w_estado_nxt = VOANDO;
          w_bola_x_nxt = (w_x_lanc > 11'd639) ? 10'd639 : w_x_lanc[9:0];
          w_bola_y_nxt = w_y_lanc;
          w_ativa_nxt  = 1'b1;
        end else if (w_tick && (r_cd != '0)) begin
          w_cd_nxt = r_cd - CD_W'(1);
        end
      end
      VOANDO: begin
        if (w_tick) begin
          w_bola_y_nxt = w_y_mov[9:0];
          if (w_acerto) begin
            w_acertou_nxt = 1'b1;
            w_ativa_nxt   = 1'b0;
            w_estado_nxt  = ESPERA;
            w_cd_nxt      = w_cd_load;
          end else if (w_fora) begin
            w_ativa_nxt  = 1'b0;
            w_estado_nxt = ESPERA;
            w_cd_nxt     = w_cd_load;
          end
        end
      end
      default: begin
        w_estado_nxt = OCIOSO;
        w_ativa_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
    if (resetInimigo) begin
      r_estado  <= OCIOSO;
      r_div     <= '0;
      r_lfsr    <= LFSR_SEED;
      r_cd      <= '0;
      r_bola_x  <= '0;
      r_bola_y  <= '0;
      r_ativa   <= 1'b0;
      r_acertou <= 1'b0;
    end else begin
      r_estado  <= w_estado_nxt;
      r_lfsr    <= {r_lfsr[6:0], w_fb};
      r_cd      <= w_cd_nxt;
      r_bola_x  <= w_bola_x_nxt;
      r_bola_y  <= w_bola_y_nxt;
      r_ativa   <= w_ativa_nxt;
      r_acertou <= w_acertou_nxt;
      if (!pausa) begin
        r_div <= (r_div == c_div_max) ? '0 : r_div + DIV_W'(1);
      end
    end
  end

  assign bola_x       = r_bola_x;
  assign bola_y       = r_bola_y;
  assign ativa        = r_ativa;
  assign acertou_nave = r_acertou;

endmodule

`default_nettype wire

// File: tb/tb_tiro_inimigo.sv
// ============================================================================
// Module   : tb_tiro_inimigo
// Purpose  : Randomised and directed bench for tiro_inimigo against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tiro_inimigo;

  localparam int TICK_DIV = 4;

  logic       CLOCK_50 = 1'b0;
  logic       resetInimigo;
  logic       pausa;
  logic       inimigo_vivo;
  logic [9:0] inimigo_x, inimigo_y, nave_x, nave_y;
  logic [9:0] bola_x, bola_y;
  logic       ativa, acertou_nave;

  always #5 CLOCK_50 = ~CLOCK_50;

  tiro_inimigo #(.TICK_DIV(TICK_DIV)) dut (
    .CLOCK_50     (CLOCK_50),
    .resetInimigo (resetInimigo),
    .pausa        (pausa),
    .inimigo_vivo (inimigo_vivo),
    .inimigo_x    (inimigo_x),
    .inimigo_y    (inimigo_y),
    .nave_x       (nave_x),
    .nave_y       (nave_y),
    .bola_x       (bola_x),
    .bola_y       (bola_y),
    .ativa        (ativa),
    .acertou_nave (acertou_nave)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: flags describe what the shot is doing, ints hold positions.
  int         m_div, m_cd, m_bx, m_by;
  logic [7:0] m_lfsr;
  bit         m_wait, m_fly, m_pulse;

  int n_pulse, n_launch, first_lx, first_ly, last_by;
  bit prev_ativa, pulse_with_ativa;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(int bx, int y, int nx, int ny);
    return (nx < bx) && (bx < nx + 33) && (ny < y) && (y < ny + 24);
  endfunction

  task automatic model_reset();
    m_div = 0; m_lfsr = 8'hA5; m_wait = 0; m_fly = 0;
    m_cd = 0; m_bx = 0; m_by = 0; m_pulse = 0;
  endtask

  task automatic model_step();
    bit tick;
    int y;
    tick    = !pausa && (m_div == TICK_DIV - 1);
    m_pulse = 0;
    if (m_fly) begin
      if (tick) begin
        y    = m_by + 4;
        m_by = y % 1024;
        if (hit(m_bx, y, int'(nave_x), int'(nave_y))) begin
          m_pulse = 1; m_fly = 0; m_wait = 1; m_cd = 50 + int'(m_lfsr[4:0]);
        end else if (y >= 480) begin
          m_fly = 0; m_wait = 1; m_cd = 50 + int'(m_lfsr[4:0]);
        end
      end
    end else if (m_wait) begin
      if (!inimigo_vivo) m_wait = 0;
      else if (m_cd == 0 && !pausa) begin
        m_wait = 0; m_fly = 1;
        m_bx = (int'(inimigo_x) + 16 > 639) ? 639 : int'(inimigo_x) + 16;
        m_by = (int'(inimigo_y) + 24) % 1024;
      end else if (tick) m_cd--;
    end else if (inimigo_vivo) begin
      m_wait = 1; m_cd = 50 + int'(m_lfsr[4:0]);
    end
    if (!pausa) m_div = (m_div + 1) % TICK_DIV;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  task automatic clear_counts();
    n_pulse = 0; n_launch = 0; first_lx = -1; first_ly = -1; pulse_with_ativa = 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLOCK_50);
    #1;
    chk("ativa", int'(ativa), int'(m_fly));
    chk("acertou_nave", int'(acertou_nave), int'(m_pulse));
    if (m_fly) begin
      chk("bola_x", int'(bola_x), m_bx);
      chk("bola_y", int'(bola_y), m_by);
    end
    if (acertou_nave) begin
      n_pulse++;
      if (ativa) pulse_with_ativa = 1;
    end
    if (ativa && !prev_ativa) begin
      n_launch++;
      if (n_launch == 1) begin first_lx = int'(bola_x); first_ly = int'(bola_y); end
    end
    if (ativa) last_by = int'(bola_y);
    prev_ativa = ativa;
  endtask

  task automatic wait_launch(input string tag, input int max);
    for (int i = 0; i < max && n_launch == 0; i++) cycle();
    chk(tag, int'(n_launch > 0), 1);
  endtask

  task automatic wait_fall(input string tag, input int max);
    for (int i = 0; i < max && ativa === 1'b1; i++) cycle();
    chk(tag, int'(ativa), 0);
  endtask

  initial begin
    int nx, cnt, exp_wait;
    resetInimigo = 1; pausa = 0; inimigo_vivo = 0;
    inimigo_x = 0; inimigo_y = 0; nave_x = 500; nave_y = 440;
    prev_ativa = 0; last_by = 0;
    model_reset();
    clear_counts();
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_ativa", int'(ativa), 0);
    chk("rst_bola_x", int'(bola_x), 0);
    chk("rst_bola_y", int'(bola_y), 0);
    chk("rst_acertou", int'(acertou_nave), 0);
    resetInimigo = 0;

    // Shot misses and leaves the screen.
    inimigo_vivo = 1; inimigo_x = 100; inimigo_y = 40;
    clear_counts();
    wait_launch("s2_launch", 400);
    chk("s2_launch_x", first_lx, 116);
    chk("s2_launch_y", first_ly, 64);
    wait_fall("s2_fall", 600);
    chk("s2_no_pulse", n_pulse, 0);
    chk("s2_last_y", last_by, 476);

    // Ship directly under the shot.
    nave_x = 100; nave_y = 300;
    clear_counts();
    wait_launch("s3_launch", 400);
    wait_fall("s3_fall", 600);
    chk("s3_pulses", n_pulse, 1);
    chk("s3_pulse_ativa_low", int'(pulse_with_ativa), 0);
    chk("s3_last_y", last_by, 300);

    // Shot on the ship's left edge: strict inequality, no hit.
    nave_x = 116;
    clear_counts();
    wait_launch("s4_launch", 400);
    wait_fall("s4_fall", 600);
    chk("s4_pulses", n_pulse, 0);
    chk("s4_last_y", last_by, 476);

    // Pause mid-flight at y=150.
    nave_x = 500; nave_y = 440; inimigo_y = 42;
    clear_counts();
    wait_launch("s5_launch", 400);
    for (int i = 0; i < 200 && m_by < 150; i++) cycle();
    chk("s5_reach150", int'(bola_y), 150);
    pausa = 1;
    repeat (100) cycle();
    chk("s5_hold", int'(bola_y), 150);
    pausa = 0;
    exp_wait = TICK_DIV - m_div;
    cnt = 0;
    for (int i = 0; i < 20 && bola_y == 10'd150; i++) begin cycle(); cnt++; end
    chk("s5_resume_wait", cnt, exp_wait);
    chk("s5_resume_y", int'(bola_y), 154);
    wait_fall("s5_fall", 600);

    // Enemy dies while waiting, then while the shot flies.
    clear_counts();
    inimigo_vivo = 0;
    repeat (50) cycle();
    chk("s6_no_launch_dead", n_launch, 0);
    inimigo_vivo = 1;
    wait_launch("s6_launch", 400);
    inimigo_vivo = 0;
    wait_fall("s6_fall", 600);
    repeat (600) cycle();
    chk("s6_no_relaunch", n_launch, 1);
    inimigo_vivo = 1;

    // Asynchronous reset mid-flight.
    inimigo_y = 40;
    clear_counts();
    wait_launch("s1_launch", 400);
    for (int i = 0; i < 300 && m_by < 200; i++) cycle();
    chk("s1_in_flight", int'(ativa), 1);
    #3 resetInimigo = 1;
    #1;
    chk("s1_ativa", int'(ativa), 0);
    chk("s1_bola_x", int'(bola_x), 0);
    chk("s1_bola_y", int'(bola_y), 0);
    chk("s1_acertou", int'(acertou_nave), 0);
    @(posedge CLOCK_50);
    #1;
    model_reset();
    prev_ativa = 0;
    resetInimigo = 0;

    // Randomised rounds with the ship placed near the shot column.
    for (int r = 0; r < 10; r++) begin
      inimigo_x = 10'($urandom_range(0, 639));
      inimigo_y = 10'($urandom_range(0, 400));
      nx = ((int'(inimigo_x) + 16 > 639) ? 639 : int'(inimigo_x) + 16) - int'($urandom_range(0, 40));
      nave_x = 10'((nx < 0) ? 0 : nx);
      nave_y = 10'($urandom_range(50, 470));
      for (int c = 0; c < 1200; c++) begin
        pausa        = ($urandom_range(0, 15) == 0);
        inimigo_vivo = ($urandom_range(0, 99) != 0);
        if ($urandom_range(0, 99) == 0) inimigo_x = 10'($urandom_range(0, 639));
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
